// File: rtl/split_mem_responder.sv
// split_mem_responder: split-transaction word RAM target with randomised accept stalls and response delays
module split_mem_responder #(
    parameter int          MEM_POW           = 10,
    parameter int          RESP_FIFO_POW     = 2,
    parameter int          REQ_RANDOM_RANGE  = 0,
    parameter int          RESP_RANDOM_RANGE = 0,
    parameter logic [15:0] LFSR_SEED         = 16'hACE1,
    parameter string       INIT_FILE         = ""
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        host_req,
    output logic        host_ack,
    input  logic        host_we,
    input  logic [31:0] host_addr,
    input  logic [31:0] host_wdata,
    input  logic [3:0]  host_be,
    output logic        host_resp,
    output logic [31:0] host_rdata
);
    localparam int DEPTH    = 1 << RESP_FIFO_POW;
    localparam int CW       = RESP_FIFO_POW + 1;
    localparam int REQ_MOD  = REQ_RANDOM_RANGE > 1 ? REQ_RANDOM_RANGE : 1;
    localparam int RESP_MOD = RESP_RANDOM_RANGE > 1 ? RESP_RANDOM_RANGE : 1;

    typedef enum logic {IDLE, WAIT} state_t;

    logic [31:0]              mem [1 << MEM_POW];
    logic [31:0]              fifo [DEPTH];
    logic [RESP_FIFO_POW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]            count;
    logic [15:0]              lfsr;
    logic [7:0]               stall_cnt, delay_cnt, req_draw, resp_draw;
    logic [MEM_POW-1:0]       word;
    logic                     accept, push, pop, unused_addr;
    state_t                   state;

    assign word        = host_addr[MEM_POW+1:2];
    assign unused_addr = ^{host_addr[31:MEM_POW+2], host_addr[1:0]};
    assign host_ack    = rst_i & host_req & (stall_cnt == '0) & (host_we | ~count[RESP_FIFO_POW]);
    assign accept      = host_req & host_ack;
    assign push        = accept & ~host_we;
    assign pop         = (state == WAIT) && (delay_cnt == '0);
    assign req_draw    = 8'({1'b0, lfsr[7:0]} % 9'(REQ_MOD));
    assign resp_draw   = 8'({1'b0, lfsr[15:8]} % 9'(RESP_MOD));

    always_ff @(posedge clk_i) begin
        if (accept && host_we) begin
            for (int b = 0; b < 4; b++) begin
                if (host_be[b]) mem[word][8*b +: 8] <= host_wdata[8*b +: 8];
            end
        end
        if (push) fifo[wr_ptr] <= mem[word];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            lfsr       <= LFSR_SEED;
            stall_cnt  <= '0;
            delay_cnt  <= '0;
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            host_resp  <= 1'b0;
            host_rdata <= '0;
        end else begin
            lfsr      <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            host_resp <= 1'b0;
            stall_cnt <= accept ? req_draw : (stall_cnt != '0 ? stall_cnt - 8'd1 : stall_cnt);
            count     <= count + CW'(push) - CW'(pop);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (state == IDLE) begin
                if (count != '0) begin
                    delay_cnt <= resp_draw;
                    state     <= WAIT;
                end
            end else if (delay_cnt == '0) begin
                host_resp  <= 1'b1;
                host_rdata <= fifo[rd_ptr];
                rd_ptr     <= rd_ptr + 1'b1;
                state      <= IDLE;
            end else begin
                delay_cnt <= delay_cnt - 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_split_mem_responder.sv
// tb_split_mem_responder: scoreboard bench over three responder configurations (no delay, backpressure, soak)
module tb_split_mem_responder;
    logic        clk = 1'b0;
    logic [2:0]  rst_n, req, we, ack, resp;
    logic [31:0] addr [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic [3:0]  be [3];
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    logic [31:0] q2 [$];
    logic [31:0] mdl [16];
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    split_mem_responder #(.REQ_RANDOM_RANGE(0), .RESP_RANDOM_RANGE(0)) dut0 (
        .clk_i(clk), .rst_i(rst_n[0]), .host_req(req[0]), .host_ack(ack[0]), .host_we(we[0]),
        .host_addr(addr[0]), .host_wdata(wdata[0]), .host_be(be[0]), .host_resp(resp[0]), .host_rdata(rdata[0]));
    split_mem_responder #(.REQ_RANDOM_RANGE(0), .RESP_RANDOM_RANGE(4)) dut1 (
        .clk_i(clk), .rst_i(rst_n[1]), .host_req(req[1]), .host_ack(ack[1]), .host_we(we[1]),
        .host_addr(addr[1]), .host_wdata(wdata[1]), .host_be(be[1]), .host_resp(resp[1]), .host_rdata(rdata[1]));
    split_mem_responder #(.REQ_RANDOM_RANGE(8), .RESP_RANDOM_RANGE(6)) dut2 (
        .clk_i(clk), .rst_i(rst_n[2]), .host_req(req[2]), .host_ack(ack[2]), .host_we(we[2]),
        .host_addr(addr[2]), .host_wdata(wdata[2]), .host_be(be[2]), .host_resp(resp[2]), .host_rdata(rdata[2]));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic int qsize(input int i);
        return i == 0 ? q0.size() : (i == 1 ? q1.size() : q2.size());
    endfunction

    function automatic logic [31:0] qpop(input int i);
        if (i == 0) return q0.pop_front();
        if (i == 1) return q1.pop_front();
        return q2.pop_front();
    endfunction

    task automatic qpush(input int i, input logic [31:0] v);
        if (i == 0) q0.push_back(v);
        else if (i == 1) q1.push_back(v);
        else q2.push_back(v);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (resp[i]) begin
                if (qsize(i) == 0) check($sformatf("spurious_resp%0d", i), 32'(resp[i]), 32'd0);
                else check($sformatf("resp_rdata%0d", i), rdata[i], qpop(i));
            end
        end
    end

    task automatic op(input int i, input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, input bit chk_ack, input bit push);
        int t = 0;
        req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d; be[i] = b;
        #1;
        if (chk_ack) check("ack_first_cycle", 32'(ack[i]), 32'd1);
        while (!ack[i] && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (!ack[i]) check("accept_timeout", 32'(ack[i]), 32'd1);
        else if (!w && push) qpush(i, d);
        @(posedge clk); #1;
        req[i] = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && t < 1000) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_pending", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
    endtask

    initial begin
        int  cnt;
        bit  wr, acc, wrote;
        logic [31:0] a, d;
        logic [3:0]  b;
        int  k;
        rst_n = '0; req = '0; we = '0;
        for (int i = 0; i < 3; i++) begin
            addr[i] = '0; wdata[i] = '0; be[i] = '0;
        end
        req[0] = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("rst_ack", 32'(ack[0]), 32'd0);
            check("rst_resp", 32'(resp[0]), 32'd0);
            check("rst_rdata", rdata[0], 32'd0);
        end
        req[0] = 1'b0;
        rst_n = '1;

        op(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 1, 0);
        op(0, 0, 32'h10, 32'hDEADBEEF, 4'h0, 1, 1);
        check("lat_e0", 32'(resp[0]), 32'd0);
        @(posedge clk); #1; check("lat_e1", 32'(resp[0]), 32'd0);
        @(posedge clk); #1; check("lat_e2", 32'(resp[0]), 32'd1);
        @(posedge clk); #1; check("lat_e3", 32'(resp[0]), 32'd0);

        op(0, 1, 32'h20, 32'h11223344, 4'hF, 1, 0);
        op(0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, 1, 0);
        op(0, 0, 32'h20, 32'h11BB33DD, 4'h0, 1, 1);
        drain();

        for (int j = 0; j < 8; j++) op(1, 1, 32'h100 + 4 * j, 32'h01010101 * (j + 1), 4'hF, 1, 0);
        cnt = 0; wrote = 0;
        for (int c = 0; c < 40; c++) begin
            wr = (cnt == 4) && !wrote;
            req[1] = 1'b1; we[1] = wr; be[1] = 4'hF; wdata[1] = c;
            addr[1] = wr ? 32'h200 : 32'h100 + 4 * (c % 8);
            #1;
            if (wr) begin
                check("bp_wr_at_full", 32'(ack[1]), 32'd1);
                wrote = 1;
            end else begin
                check("bp_rd_ack", 32'(ack[1]), 32'(cnt < 4));
            end
            acc = ack[1] && !wr;
            if (acc) q1.push_back(32'h01010101 * ((c % 8) + 1));
            @(posedge clk); #1;
            cnt = cnt + int'(acc) - int'(resp[1]);
        end
        req[1] = 1'b0;
        check("bp_full_reached", 32'(wrote), 32'd1);
        drain();

        op(0, 1, 32'h1004, 32'hCAFE0001, 4'hF, 1, 0);
        op(0, 0, 32'h4, 32'h0, 4'h0, 1, 0);
        op(0, 0, 32'h4, 32'h0, 4'h0, 1, 0);
        rst_n[0] = 1'b0; req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h4;
        #1;
        check("rst_prio_ack", 32'(ack[0]), 32'd0);
        @(posedge clk); #1;
        rst_n[0] = 1'b1; req[0] = 1'b0;
        check("midrst_rdata", rdata[0], 32'd0);
        repeat (6) begin
            @(posedge clk); #1;
            check("midrst_no_resp", 32'(resp[0]), 32'd0);
        end
        op(0, 0, 32'h4, 32'hCAFE0001, 4'h0, 1, 1);
        drain();

        for (int j = 0; j < 16; j++) begin
            mdl[j] = $urandom();
            op(2, 1, 32'h300 + 4 * j, mdl[j], 4'hF, 0, 0);
        end
        for (int n = 0; n < 2000; n++) begin
            k = $urandom_range(15);
            a = ($urandom() & 32'hFFFFF000) | ((32'hC0 + k) << 2) | 32'($urandom_range(3));
            if ($urandom_range(1) == 0) begin
                op(2, 0, a, mdl[k], 4'h0, 0, 1);
            end else begin
                d = $urandom();
                b = 4'($urandom_range(15));
                for (int bb = 0; bb < 4; bb++) if (b[bb]) mdl[k][8*bb +: 8] = d[8*bb +: 8];
                op(2, 1, a, d, b, 0, 0);
            end
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
